ifu_fetch: RTL
==============

Name: ifu_fetch

Overview:
- Instruction-fetch unit that generates the PC, issues word reads on the instruction bus, and buffers the returned words.
- It presents one instruction per cycle to the IF/ID pipeline register, which samples inst_o/inst_addr_o every cycle unless the stall level is Hold_Id or higher.
- It honours the ctrl block's hold levels and jump redirects, and discards stale responses after a redirect.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries; must be a power of two, 2..4.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-low reset
- jump_flag_i  in  1  redirect request from ex/ctrl
- jump_addr_i  in  32  redirect target; bits[1:0] ignored (treated as 0)
- hold_flag_i  in  3  ctrl stall level: 0 none, 1 Hold_Pc, 2 Hold_If, 3 Hold_Id
- ibus_req_o  out  1  read request valid
- ibus_addr_o  out  32  word-aligned read address
- ibus_gnt_i  in  1  request accepted this cycle
- ibus_rvalid_i  in  1  read data valid
- ibus_rdata_i  in  32  read data
- inst_o  out  32  instruction to IF/ID
- inst_addr_o  out  32  address of inst_o
- inst_valid_o  out  1  inst_o is a real fetched word

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, FIFO empty, state IDLE, ibus_req_o=0, ibus_addr_o=RESET_PC.
  - inst_o=INST_NOP (32'h00000001), inst_addr_o=ZeroWord, inst_valid_o=0.
- Bus protocol:
  - At most one outstanding read.
  - Once asserted, ibus_req_o/ibus_addr_o stay stable until ibus_gnt_i.
  - ibus_rvalid_i arrives no earlier than the cycle after grant.
  - rvalid without an outstanding request is ignored.
- State machine:
  - IDLE -> REQ: when no outstanding read, FIFO has a free slot counting the in-flight entry, and hold_flag_i < Hold_Pc.
  - REQ: ibus_req_o=1, ibus_addr_o=pc. On gnt, pc <= pc+4 (wraps 32'hFFFF_FFFC -> 0) and go to WAIT.
  - WAIT: on rvalid, push {pc_of_request, rdata} into the FIFO. Then go to REQ if the issue conditions still hold, otherwise IDLE. A new request may assert in the same cycle as rvalid.
  - FLUSH: entered from WAIT on jump. On rvalid, drop the data, go to REQ, and issue to jump target.
- Jump (jump_flag_i=1), highest priority:
  - FIFO cleared and pc <= {jump_addr_i[31:2],2'b00} in the same cycle.
  - If a read is outstanding (WAIT), go to FLUSH. If in REQ but not yet granted, retarget the address to the jump target next cycle.
  - A jump in the same cycle as a grant means the granted read is stale: go to FLUSH.
  - A jump in the same cycle as rvalid drops that data.
- Output / pop:
  - Output is the FIFO head, registered view.
  - Pop when head valid and hold_flag_i < Hold_If.
  - If the FIFO is empty, or on the cycle after a jump, inst_o=INST_NOP, inst_valid_o=0, inst_addr_o=pc.
  - Push and pop in the same cycle are allowed. Push to a full FIFO cannot happen, because issue reserves the slot.
- Hold levels:
  - hold_flag_i >= Hold_Pc: no new requests issue. Outstanding reads still complete and push.
  - hold_flag_i >= Hold_If: no pops; output is held stable.
- Latency: with a zero-wait bus (gnt same cycle, rvalid next cycle), inst_valid_o rises 2 cycles after reset release. Sustained throughput is 1 instruction per 2 cycles, or 1 per cycle with request/response overlap.

Test Plan:
- Reset release, zero-wait bus returning word = address:
  - inst_valid_o rises cycle 2.
  - inst_addr_o sequence 0,4,8,... with inst_o matching.
  - no NOP gaps after first fill.
- Jump to 32'h0000_0103 while a read of 0x10 is outstanding:
  - rvalid data for 0x10 is dropped.
  - next valid output is addr 32'h100.
  - no instruction from 0x10 or 0x14 ever appears with inst_valid_o=1.
- hold_flag_i=3'b010 for 5 cycles with FIFO full:
  - inst_o/inst_addr_o unchanged.
  - ibus_req_o=0 once FIFO plus in-flight reaches FIFO_DEPTH.
  - resumes in order at release.
- Grant delayed 3 cycles: ibus_addr_o/ibus_req_o stay stable until gnt; pc advances only on gnt.
- pc=32'hFFFF_FFFC fetched: next request address is 32'h0000_0000.
- Assert rst low mid-WAIT:
  - outputs return to reset values immediately, without waiting for a clock edge.
  - a later stray rvalid is ignored.
  - fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: PC generation, single-outstanding instruction-bus reads,
// and a small buffer of returned words presented one per cycle to IF/ID.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic [2:0]  hold_flag_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
);
  localparam logic [31:0] INST_NOP = 32'h0000_0001;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FLUSH} state_t;

  state_t        r_state, w_state_nxt;
  logic [31:0]   r_pc, r_req_pc;
  logic [31:0]   r_fifo_addr [FIFO_DEPTH];
  logic [31:0]   r_fifo_data [FIFO_DEPTH];
  logic [PW-1:0] r_rd_ptr, r_wr_ptr;
  logic [CW-1:0] r_cnt, w_cnt_after;
  logic          w_head_vld, w_pop, w_push, w_rsp, w_bus_free, w_issue, w_req, w_gnt;
  logic [31:0]   w_jump_pc;
  logic          w_unused_jmp_lsb;

  assign w_jump_pc        = {jump_addr_i[31:2], 2'b00};
  assign w_unused_jmp_lsb = ^jump_addr_i[1:0];
  assign w_head_vld       = (r_cnt != '0);
  assign w_pop            = w_head_vld && (hold_flag_i < 3'd2);
  assign w_rsp            = ((r_state == S_WAIT) || (r_state == S_FLUSH)) && ibus_rvalid_i;
  assign w_push           = (r_state == S_WAIT) && ibus_rvalid_i && !jump_flag_i;
  assign w_cnt_after      = r_cnt + CW'(w_push) - CW'(w_pop);
  // Bus is free when idle or when the outstanding read retires this cycle, so a
  // new request can overlap the response; the slot check counts that push.
  assign w_bus_free       = (r_state == S_IDLE) || w_rsp;
  assign w_issue          = w_bus_free && !jump_flag_i && (hold_flag_i == 3'd0) &&
                            (w_cnt_after < CW'(FIFO_DEPTH));
  assign w_gnt            = w_req && ibus_gnt_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_bus_free) begin
      if (w_issue) w_state_nxt = ibus_gnt_i ? S_WAIT : S_REQ;
      else         w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_REQ:   if (ibus_gnt_i) w_state_nxt = jump_flag_i ? S_FLUSH : S_WAIT;
        S_WAIT:  if (jump_flag_i) w_state_nxt = S_FLUSH;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_req      = (r_state == S_REQ) || w_issue;
    ibus_req_o = rst && w_req;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc     <= RESET_PC;
      r_req_pc <= RESET_PC;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (jump_flag_i) r_pc <= w_jump_pc;
      else if (w_gnt)  r_pc <= r_pc + 32'd4;
      if (w_gnt) r_req_pc <= r_pc;
      if (jump_flag_i) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_cnt    <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        r_cnt <= w_cnt_after;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= r_req_pc;
      r_fifo_data[r_wr_ptr] <= ibus_rdata_i;
    end
  end

  assign ibus_addr_o  = r_pc;
  assign inst_valid_o = w_head_vld;
  assign inst_o       = w_head_vld ? r_fifo_data[r_rd_ptr] : INST_NOP;
  assign inst_addr_o  = w_head_vld ? r_fifo_addr[r_rd_ptr] : (rst ? r_pc : 32'h0);
endmodule
